// File: rtl/mem_pkg.sv
// Shared constants for the accelerator memory front end: bank-select codes
// and default bank geometry.
package mem_pkg;

  localparam logic [1:0] SEL_WEIGHTS = 2'b00;
  localparam logic [1:0] SEL_INTER   = 2'b01;
  localparam logic [1:0] SEL_IO      = 2'b10;
  localparam logic [1:0] SEL_RSVD    = 2'b11;

  localparam int DEF_DATA_W       = 16;
  localparam int DEF_ADDR_W       = 16;
  localparam int DEF_WEIGHT_DEPTH = 1024;
  localparam int DEF_INTER_DEPTH  = 1024;
  localparam int DEF_IO_DEPTH     = 256;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with a registered, read-first output: a write
// cycle returns the word that was stored before the write.
module sp_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
    rdata_d = mem_q[addr];
  end

  // Storage is never reset; contents persist across rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_manager.sv
// Three-bank memory front end (weights, intermediate, I/O buffer) on one shared
// bus with one-cycle registered read latency.
module memory_manager
  import mem_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int WEIGHT_DEPTH = DEF_WEIGHT_DEPTH,
  parameter int INTER_DEPTH  = DEF_INTER_DEPTH,
  parameter int IO_DEPTH     = DEF_IO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_enable,
  input  logic [1:0]        mem_select,
  output logic [DATA_W-1:0] data_out
);

  localparam int W_AW  = $clog2(WEIGHT_DEPTH);
  localparam int I_AW  = $clog2(INTER_DEPTH);
  localparam int IO_AW = $clog2(IO_DEPTH);

  // No handshake: every cycle is one complete access; there is no valid/ready pair.
  logic              in_range;
  logic              we_w, we_i, we_io;
  logic              hit_d, hit_q;
  logic [1:0]        sel_d, sel_q;
  logic [DATA_W-1:0] rd_w, rd_i, rd_io;
  logic [DATA_W-1:0] data_out_mux;

  always_comb begin
    in_range = 1'b0;
    case (mem_select)
      SEL_WEIGHTS: in_range = 32'(address) < WEIGHT_DEPTH;
      SEL_INTER:   in_range = 32'(address) < INTER_DEPTH;
      SEL_IO:      in_range = 32'(address) < IO_DEPTH;
      default:     in_range = 1'b0;
    endcase
    hit_d = in_range;
    sel_d = mem_select;
    // Out-of-range addresses must never reach a bank, so no truncated alias is written.
    we_w  = write_enable && !rst && in_range && (mem_select == SEL_WEIGHTS);
    we_i  = write_enable && !rst && in_range && (mem_select == SEL_INTER);
    we_io = write_enable && !rst && in_range && (mem_select == SEL_IO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q <= 1'b0;
      sel_q <= SEL_RSVD;
    end else begin
      hit_q <= hit_d;
      sel_q <= sel_d;
    end
  end

  sp_ram #(.DATA_W(DATA_W), .DEPTH(WEIGHT_DEPTH)) u_weights (
    .clk(clk), .we(we_w), .addr(address[W_AW-1:0]), .wdata(data_in), .rdata(rd_w)
  );

  sp_ram #(.DATA_W(DATA_W), .DEPTH(INTER_DEPTH)) u_inter (
    .clk(clk), .we(we_i), .addr(address[I_AW-1:0]), .wdata(data_in), .rdata(rd_i)
  );

  sp_ram #(.DATA_W(DATA_W), .DEPTH(IO_DEPTH)) u_io (
    .clk(clk), .we(we_io), .addr(address[IO_AW-1:0]), .wdata(data_in), .rdata(rd_io)
  );

  // Mux inputs are all flops, so data_out only moves at clock edges; reset clears hit_q.
  always_comb begin
    data_out_mux = '0;
    if (hit_q) begin
      case (sel_q)
        SEL_WEIGHTS: data_out_mux = rd_w;
        SEL_INTER:   data_out_mux = rd_i;
        SEL_IO:      data_out_mux = rd_io;
        default:     data_out_mux = '0;
      endcase
    end
  end

  assign data_out = data_out_mux;

endmodule

// File: tb/tb_memory_manager.sv
// Directed self-checking bench for memory_manager: reset, per-bank access,
// read-first, range boundaries, reserved select and back-to-back reads.
module tb_memory_manager;
  import mem_pkg::*;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic [15:0] address;
  logic        write_enable;
  logic [1:0]  mem_select;
  logic [15:0] data_out;

  int checks = 0;
  int errors = 0;

  memory_manager dut (
    .clk(clk), .rst(rst), .data_in(data_in), .address(address),
    .write_enable(write_enable), .mem_select(mem_select), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, exp finish");
    $fatal(1, "watchdog expired");
  end

  // Drive one access at the falling edge, then settle 1 time unit past the rising edge.
  task automatic access(input logic r, input logic we, input logic [1:0] sel,
                        input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    rst = r; write_enable = we; mem_select = sel; address = addr; data_in = data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    access(1'b1, 1'b1, SEL_WEIGHTS, 16'd0, 16'hFFFF);
    checks++;
    if (data_out !== 16'h0000) begin
      errors++; $display("FAIL reset_cycle1: got %h exp %h", data_out, 16'h0000);
    end
    access(1'b1, 1'b1, SEL_WEIGHTS, 16'd0, 16'hFFFF);
    checks++;
    if (data_out !== 16'h0000) begin
      errors++; $display("FAIL reset_cycle2: got %h exp %h", data_out, 16'h0000);
    end
    access(1'b0, 1'b0, SEL_WEIGHTS, 16'd0, 16'h0000);
    checks++;
    if (data_out === 16'hFFFF) begin
      errors++; $display("FAIL reset_write_suppressed: got %h exp not %h", data_out, 16'hFFFF);
    end
  endtask

  task automatic test_bank_rw;
    access(1'b0, 1'b1, SEL_WEIGHTS, 16'd0, 16'h1234);
    access(1'b0, 1'b0, SEL_WEIGHTS, 16'd0, 16'h0000);
    checks++;
    if (data_out !== 16'h1234) begin
      errors++; $display("FAIL rw_weights0: got %h exp %h", data_out, 16'h1234);
    end
    access(1'b0, 1'b1, SEL_INTER, 16'd0, 16'h5678);
    access(1'b0, 1'b0, SEL_INTER, 16'd0, 16'h0000);
    checks++;
    if (data_out !== 16'h5678) begin
      errors++; $display("FAIL rw_inter0: got %h exp %h", data_out, 16'h5678);
    end
    access(1'b0, 1'b1, SEL_IO, 16'd0, 16'h9ABC);
    access(1'b0, 1'b0, SEL_IO, 16'd0, 16'h0000);
    checks++;
    if (data_out !== 16'h9ABC) begin
      errors++; $display("FAIL rw_io0: got %h exp %h", data_out, 16'h9ABC);
    end
    access(1'b0, 1'b0, SEL_WEIGHTS, 16'd0, 16'h0000);
    checks++;
    if (data_out !== 16'h1234) begin
      errors++; $display("FAIL rw_isolation_w0: got %h exp %h", data_out, 16'h1234);
    end
  endtask

  task automatic test_read_first;
    access(1'b0, 1'b1, SEL_INTER, 16'd5, 16'hAAAA);
    access(1'b0, 1'b1, SEL_INTER, 16'd5, 16'hBBBB);
    checks++;
    if (data_out !== 16'hAAAA) begin
      errors++; $display("FAIL read_first_old: got %h exp %h", data_out, 16'hAAAA);
    end
    access(1'b0, 1'b0, SEL_INTER, 16'd5, 16'h0000);
    checks++;
    if (data_out !== 16'hBBBB) begin
      errors++; $display("FAIL read_first_new: got %h exp %h", data_out, 16'hBBBB);
    end
  endtask

  task automatic test_boundaries;
    access(1'b0, 1'b1, SEL_WEIGHTS, 16'd1023, 16'h0001);
    access(1'b0, 1'b1, SEL_IO, 16'd255, 16'h0002);
    access(1'b0, 1'b0, SEL_WEIGHTS, 16'd1023, 16'h0000);
    checks++;
    if (data_out !== 16'h0001) begin
      errors++; $display("FAIL bound_w1023: got %h exp %h", data_out, 16'h0001);
    end
    access(1'b0, 1'b0, SEL_IO, 16'd255, 16'h0000);
    checks++;
    if (data_out !== 16'h0002) begin
      errors++; $display("FAIL bound_io255: got %h exp %h", data_out, 16'h0002);
    end
    access(1'b0, 1'b1, SEL_IO, 16'd256, 16'h0003);
    checks++;
    if (data_out !== 16'h0000) begin
      errors++; $display("FAIL oor_write_cycle: got %h exp %h", data_out, 16'h0000);
    end
    access(1'b0, 1'b0, SEL_IO, 16'd256, 16'h0000);
    checks++;
    if (data_out !== 16'h0000) begin
      errors++; $display("FAIL oor_read_io256: got %h exp %h", data_out, 16'h0000);
    end
    access(1'b0, 1'b0, SEL_IO, 16'd0, 16'h0000);
    checks++;
    if (data_out !== 16'h9ABC) begin
      errors++; $display("FAIL oor_no_alias_io0: got %h exp %h", data_out, 16'h9ABC);
    end
    access(1'b0, 1'b0, SEL_WEIGHTS, 16'd1024, 16'h0000);
    checks++;
    if (data_out !== 16'h0000) begin
      errors++; $display("FAIL oor_read_w1024: got %h exp %h", data_out, 16'h0000);
    end
  endtask

  task automatic test_reserved;
    access(1'b0, 1'b1, SEL_RSVD, 16'd0, 16'h7777);
    access(1'b0, 1'b0, SEL_RSVD, 16'd0, 16'h0000);
    checks++;
    if (data_out !== 16'h0000) begin
      errors++; $display("FAIL rsvd_read: got %h exp %h", data_out, 16'h0000);
    end
    access(1'b0, 1'b0, SEL_WEIGHTS, 16'd0, 16'h0000);
    checks++;
    if (data_out !== 16'h1234) begin
      errors++; $display("FAIL rsvd_keep_w0: got %h exp %h", data_out, 16'h1234);
    end
    access(1'b0, 1'b0, SEL_INTER, 16'd0, 16'h0000);
    checks++;
    if (data_out !== 16'h5678) begin
      errors++; $display("FAIL rsvd_keep_i0: got %h exp %h", data_out, 16'h5678);
    end
    access(1'b0, 1'b0, SEL_IO, 16'd0, 16'h0000);
    checks++;
    if (data_out !== 16'h9ABC) begin
      errors++; $display("FAIL rsvd_keep_io0: got %h exp %h", data_out, 16'h9ABC);
    end
  endtask

  // Expected queue: each pushed word must appear exactly one edge after its address.
  task automatic test_back_to_back;
    logic [15:0] exp_q[$];
    logic [15:0] bank_word [3];
    logic [15:0] prev, exp;
    bank_word[0] = 16'h1234;
    bank_word[1] = 16'h5678;
    bank_word[2] = 16'h9ABC;
    prev = 16'h9ABC;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rst = 1'b0; write_enable = 1'b0; mem_select = 2'(i % 3);
      address = 16'd0; data_in = 16'h0000;
      exp_q.push_back(bank_word[i % 3]);
      #1;
      checks++;
      if (data_out !== prev) begin
        errors++; $display("FAIL b2b_hold[%0d]: got %h exp %h", i, data_out, prev);
      end
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if (data_out !== exp) begin
        errors++; $display("FAIL b2b_lag[%0d]: got %h exp %h", i, data_out, exp);
      end
      prev = exp;
    end
  endtask

  task automatic test_reset_midrun;
    access(1'b1, 1'b1, SEL_WEIGHTS, 16'd0, 16'hDEAD);
    checks++;
    if (data_out !== 16'h0000) begin
      errors++; $display("FAIL midreset_out: got %h exp %h", data_out, 16'h0000);
    end
    access(1'b0, 1'b0, SEL_WEIGHTS, 16'd0, 16'h0000);
    checks++;
    if (data_out !== 16'h1234) begin
      errors++; $display("FAIL midreset_no_write: got %h exp %h", data_out, 16'h1234);
    end
  endtask

  initial begin
    rst = 1'b1; write_enable = 1'b0; mem_select = SEL_WEIGHTS;
    address = 16'd0; data_in = 16'h0000;
    test_reset();
    test_bank_rw();
    test_read_first();
    test_boundaries();
    test_reserved();
    test_back_to_back();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_manager.md
Name: memory_manager

Overview:
- Single-port memory front end for the accelerator datapath. It holds three independent on-chip banks: weights, intermediate activations, and the I/O buffer.
- One shared 16-bit data/address bus. A 2-bit select steers each access to one bank.
- Sits between the layer controller / DMA and the compute array, and supplies stored words with one-cycle registered read latency.

Parameters:
- DATA_W, 16, word width of all banks and buses
- ADDR_W, 16, width of address port
- WEIGHT_DEPTH, 1024, words in weights bank (sel 2'b00)
- INTER_DEPTH, 1024, words in intermediate bank (sel 2'b01)
- IO_DEPTH, 256, words in I/O buffer bank (sel 2'b10)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- data_in  input  DATA_W  write data
- address  input  ADDR_W  word address within selected bank
- write_enable  input  1  1 = write data_in this cycle, 0 = read
- mem_select  input  2  00 weights, 01 intermediate, 10 I/O buffer, 11 reserved
- data_out  output  DATA_W  registered read data

Behaviour:
- Reset: when rst is high at a clock edge, data_out <= 0 and any write that cycle is suppressed.
  - Bank contents are not cleared by reset. They hold prior values; power-up contents are undefined.
- Write: at a rising edge with rst=0, write_enable=1, a valid mem_select and address < depth of the selected bank, the selected bank[address] <= data_in.
  - Only the selected bank changes.
- Read: at every rising edge with rst=0 and write_enable=0, data_out <= selected bank[address].
  - Read latency is 1 cycle: data is valid after the edge that samples the address.
- Read-first on write cycles: when write_enable=1, data_out <= old content of selected bank[address]. The newly written word is visible on the next read.
- Out-of-range address (address >= depth of selected bank): write ignored, no wrap or aliasing; read returns 0.
- mem_select = 11: write ignored; read returns 0.
- Banks are fully independent: the same address in different banks holds different words.
- Changing mem_select or address between cycles has no hazard. Each edge uses only that cycle's inputs.
- data_out changes only at clock edges and holds its value between edges.
- No handshake; an access completes every cycle. No back-pressure.

Decomposition:
- Shared package mem_pkg:
  - bank-select constants SEL_WEIGHTS=2'b00, SEL_INTER=2'b01, SEL_IO=2'b10, SEL_RSVD=2'b11
  - default depth and width constants
- Sub-module sp_ram (parameters DATA_W, DEPTH): single-port synchronous RAM with write enable and read-first registered output. Instantiate it three times.
- Top level handles:
  - select decode
  - range check
  - output mux, zero-forcing for invalid or out-of-range reads, and reset of data_out.

Test Plan:
- Reset: hold rst=1 for 2 cycles with write_enable=1, sel=00, addr=0, data=16'hFFFF -> data_out=0000. A following read of weights[0] does not return FFFF unless written after reset.
- Per-bank write/read:
  - write 1234 to weights[0]; next cycle read -> data_out=1234
  - write 5678 to intermediate[0]; read -> 5678
  - write 9ABC to I/O[0]; read -> 9ABC
  - re-read weights[0] -> 1234 (bank isolation)
- Read-first: write AAAA to intermediate[5], then write BBBB to intermediate[5] -> data_out=AAAA after the second write edge; next read -> BBBB.
- Boundaries:
  - write 0001 to weights[1023] and 0002 to I/O[255]; reads return 0001 and 0002
  - write 0003 to I/O[256]; read I/O[256] -> 0000, and I/O[0] is unchanged
- Reserved select: sel=11, write 7777 to addr 0 -> read with sel=11 gives 0000; weights[0], intermediate[0] and I/O[0] are unchanged.
- Back-to-back reads across banks: alternate sel 00/01/10 every cycle at addr 0 -> data_out follows 1234/5678/9ABC with exactly 1-cycle lag.
